l2_mem_write_buffer: RTL and testbench
======================================

Name: l2_mem_write_buffer

Overview:
Posted write buffer between the L2 cache memory port and main memory. L2 dirty-line writebacks are absorbed into a small FIFO and acknowledged quickly. The FIFO drains to memory in the background. Line reads are forwarded from the buffer on an address match, otherwise passed through to memory ahead of pending drains.

Parameters:
DEPTH, 4, number of buffered 128-bit line entries (power of two, >=2)
PTRW, 2, log2(DEPTH)
ADDRW, 28, line address width
LINEW, 128, line data width

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
up_read  in  1  L2 line read request, held until up_ready
up_write  in  1  L2 line write request, held until up_ready
up_addr  in  ADDRW  L2 line address
up_wdata  in  LINEW  L2 writeback data
up_rdata  out  LINEW  read data, valid while up_ready=1
up_ready  out  1  one-cycle completion pulse to L2
mem_read  out  1  memory read request, held until mem_ready
mem_write  out  1  memory write request, held until mem_ready
mem_addr  out  ADDRW  memory line address
mem_wdata  out  LINEW  memory write data
mem_rdata  in  LINEW  memory read data, valid with mem_ready
mem_ready  in  1  memory completion pulse
occupancy  out  PTRW+1  number of valid FIFO entries

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high. All outputs are registered.
- Reset: all outputs 0, head=tail=count=0, state IDLE. Reset mid-operation abandons any memory op and discards buffered lines (documented data loss). Reset has priority over every event.
- Upstream requests are sampled only when up_ready=0. L2 outputs are registered, so the request is still asserted during the ready pulse and must not be re-accepted. up_read and up_write both high is illegal; treat it as a write.
- FSM states: IDLE, RD_MEM, WR_MEM.
- Write, not full: the write is accepted at cycle t and up_ready=1 at t+1.
  - If up_addr matches a valid entry that is not the in-flight head, that entry's data is overwritten (coalesce) and count is unchanged.
  - Otherwise the line is written at tail, tail wraps mod DEPTH, and count increments.
- Write, full (count==DEPTH) with no coalesce match: the request is held and no ready is given. It is accepted the cycle after a pop frees a slot.
- Read, buffer hit: compare up_addr against all valid entries, including the in-flight head. The newest match wins. At t+1: up_ready=1 and up_rdata=entry data. No memory access.
- Read, buffer miss:
  - In IDLE: mem_read=1 and mem_addr=up_addr at t+1; enter RD_MEM.
  - In WR_MEM: wait for the drain to complete, then issue the read.
  - On mem_ready at cycle u: up_rdata=mem_rdata and up_ready=1 at u+1; mem_read=0 at u+1; return to IDLE.
- Drain: in IDLE with count>0 and no pending upstream read miss, mem_write=1, mem_addr and mem_wdata from head at the next cycle; enter WR_MEM.
  - On mem_ready: pop (head wraps, count decrements), mem_write=0 next cycle, return to IDLE.
  - When count==DEPTH the drain takes priority over a read miss to guarantee progress.
- Simultaneous events:
  - An upstream write may be enqueued in the same cycle as a drain pop. count then stays the same.
  - Occupancy reflects the post-edge value.
- mem_read and mem_write are never both 1. A request stays asserted, with stable address and data, until mem_ready.
- Pointers: PTRW bits with natural wrap. count is PTRW+1 bits, saturating at DEPTH by construction.

Decomposition:
- Shared package l2_mem_pkg holds ADDRW and LINEW, the FSM state encoding (IDLE/RD_MEM/WR_MEM), and a wb_entry struct {valid, addr, data}.
- One natural sub-module, wb_cam_fifo: the storage, head/tail/count, and the parallel address compare. It returns a hit flag, hit index (newest), and head entry.
- The top level holds the FSM and the handshake registers.

Test Plan:
- Reset, then write A=0x0000010, D=0xAA..: up_ready at t+1, occupancy=1; mem_write with addr 0x0000010 next idle cycle; mem_ready -> occupancy=0.
- Write A with D1, then write A with D2 before the drain starts: occupancy stays 1; the drained data equals D2.
- Hold mem_ready low; write 4 distinct lines, then a 5th: no up_ready for the 5th until the first mem_ready; then it is accepted, with occupancy 4 on the cycle after.
- Buffer A=0x5 with D=0x1234; read A: up_ready at t+1 with up_rdata=0x1234; mem_read never asserted.
- Read a miss B=0x9 while a drain is in flight: mem_read waits for the write's mem_ready, then asserts with addr 0x9. Return mem_rdata=0xBEEF -> up_rdata=0xBEEF, up_ready one cycle later.
- Assert reset during RD_MEM with 2 entries buffered: next cycle all outputs 0, occupancy=0, state IDLE; a later read issues a fresh mem_read.

Source files
------------

// File: rtl/l2_mem_pkg.sv
// rtl/l2_mem_pkg.sv - shared widths, FSM encoding and write-buffer entry type
package l2_mem_pkg;

   localparam int ADDRW = 28;    // line address width
   localparam int LINEW = 128;   // line data width

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RD_MEM = 2'd1,
      WR_MEM = 2'd2
   } wb_state_t;

   typedef struct packed {
      logic             valid;
      logic [ADDRW-1:0] addr;
      logic [LINEW-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_cam_fifo.sv
// rtl/wb_cam_fifo.sv - line FIFO with parallel address compare and coalescing
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   write_en       : accepted upstream write (coalesces on wr_hit, else appends)
//   addr, wdata    : upstream line address (also the lookup key) and data
//   pop            : retire the head entry
//   excl_head      : head is (or is becoming) in flight, do not coalesce into it
//   rd_hit/rd_data : newest valid entry matching addr, head included
//   wr_hit         : newest valid match eligible for coalescing
//   head_addr/data : oldest entry
//   count          : number of valid entries
module wb_cam_fifo
   import l2_mem_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTRW  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             write_en,
   input  logic [ADDRW-1:0] addr,
   input  logic [LINEW-1:0] wdata,
   input  logic             pop,
   input  logic             excl_head,
   output logic             rd_hit,
   output logic [LINEW-1:0] rd_data,
   output logic             wr_hit,
   output logic [ADDRW-1:0] head_addr,
   output logic [LINEW-1:0] head_data,
   output logic [PTRW:0]    count
);

   wb_entry_t       entries [DEPTH];
   logic [PTRW-1:0] head;
   logic [PTRW-1:0] tail;
   logic [PTRW-1:0] idx;
   logic [PTRW-1:0] rd_idx;
   logic [PTRW-1:0] wr_idx;

   // Walk from oldest to newest so the last match seen is the newest one.
   // Duplicates only arise when a write lands behind an in-flight head.
   always_comb begin
      rd_hit = 1'b0;
      rd_idx = '0;
      wr_hit = 1'b0;
      wr_idx = '0;
      idx    = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PTRW'(k);
         if (entries[idx].valid && entries[idx].addr == addr) begin
            rd_hit = 1'b1;
            rd_idx = idx;
            if (!(excl_head && k == 0)) begin
               wr_hit = 1'b1;
               wr_idx = idx;
            end
         end
      end
   end

   assign rd_data   = entries[rd_idx].data;
   assign head_addr = entries[head].addr;
   assign head_data = entries[head].data;

   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries[i].valid <= 1'b0;
         end
      end else begin
         if (write_en) begin
            if (wr_hit) begin
               entries[wr_idx].data <= wdata;
            end else begin
               entries[tail] <= '{valid: 1'b1, addr: addr, data: wdata};
               tail          <= tail + 1'b1;
            end
         end
         if (pop) begin
            entries[head].valid <= 1'b0;
            head                <= head + 1'b1;
         end
         // A push and a pop on the same edge leave count unchanged.
         case ({write_en && !wr_hit, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/l2_mem_write_buffer.sv
// rtl/l2_mem_write_buffer.sv - posted L2 writeback buffer in front of main memory
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   up_read/up_write/up_addr/wdata  : L2 request, held until up_ready
//   up_rdata/up_ready               : read data and one-cycle completion pulse
//   mem_read/mem_write/addr/wdata   : memory request, held until mem_ready
//   mem_rdata/mem_ready             : memory read data and completion pulse
//   occupancy                       : buffered line count
module l2_mem_write_buffer
   import l2_mem_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTRW  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             up_read,
   input  logic             up_write,
   input  logic [ADDRW-1:0] up_addr,
   input  logic [LINEW-1:0] up_wdata,
   output logic [LINEW-1:0] up_rdata,
   output logic             up_ready,
   output logic             mem_read,
   output logic             mem_write,
   output logic [ADDRW-1:0] mem_addr,
   output logic [LINEW-1:0] mem_wdata,
   input  logic [LINEW-1:0] mem_rdata,
   input  logic             mem_ready,
   output logic [PTRW:0]    occupancy
);

   wb_state_t        state;
   logic             rd_hit;
   logic             wr_hit;
   logic [LINEW-1:0] rd_data;
   logic [ADDRW-1:0] head_addr;
   logic [LINEW-1:0] head_data;
   logic [PTRW:0]    count;

   logic sample, req_wr, req_rd, full, rd_miss;
   logic drain_start, rd_start, wr_accept, rd_serve, pop, excl_head;

   // The request is still asserted during our ready pulse, and in RD_MEM the
   // held request is the read already being serviced.
   assign sample      = !up_ready && state != RD_MEM;
   assign req_wr      = sample && up_write;
   assign req_rd      = sample && up_read && !up_write;
   assign full        = count == (PTRW+1)'(DEPTH);
   assign rd_miss     = req_rd && !rd_hit;
   // A full buffer drains ahead of a read miss so writers always make progress.
   assign drain_start = state == IDLE && count != '0 && (!rd_miss || full);
   assign rd_start    = state == IDLE && rd_miss && !drain_start;
   assign wr_accept   = req_wr && (wr_hit || !full);
   assign rd_serve    = req_rd && rd_hit;
   assign pop         = state == WR_MEM && mem_ready;
   // The head's data is captured into mem_wdata when the drain starts, so it
   // must not be coalesced into from that edge on.
   assign excl_head   = state == WR_MEM || drain_start;

   wb_cam_fifo #(.DEPTH(DEPTH), .PTRW(PTRW)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .write_en  (wr_accept),
      .addr      (up_addr),
      .wdata     (up_wdata),
      .pop       (pop),
      .excl_head (excl_head),
      .rd_hit    (rd_hit),
      .rd_data   (rd_data),
      .wr_hit    (wr_hit),
      .head_addr (head_addr),
      .head_data (head_data),
      .count     (count)
   );

   assign occupancy = count;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         up_ready  <= 1'b0;
         up_rdata  <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         up_ready <= wr_accept || rd_serve;
         if (rd_serve) begin
            up_rdata <= rd_data;
         end
         case (state)
            IDLE: begin
               if (drain_start) begin
                  mem_write <= 1'b1;
                  mem_addr  <= head_addr;
                  mem_wdata <= head_data;
                  state     <= WR_MEM;
               end else if (rd_start) begin
                  mem_read <= 1'b1;
                  mem_addr <= up_addr;
                  state    <= RD_MEM;
               end
            end
            RD_MEM: begin
               if (mem_ready) begin
                  mem_read <= 1'b0;
                  up_ready <= 1'b1;
                  up_rdata <= mem_rdata;
                  state    <= IDLE;
               end
            end
            WR_MEM: begin
               if (mem_ready) begin
                  mem_write <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l2_mem_write_buffer.sv
// tb/tb_l2_mem_write_buffer.sv - self-checking bench for l2_mem_write_buffer
module tb_l2_mem_write_buffer;
   import l2_mem_pkg::*;

   localparam int DEPTH = 4;
   localparam int PTRW  = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             up_read, up_write;
   logic [ADDRW-1:0] up_addr;
   logic [LINEW-1:0] up_wdata;
   logic [LINEW-1:0] up_rdata;
   logic             up_ready;
   logic             mem_read, mem_write;
   logic [ADDRW-1:0] mem_addr;
   logic [LINEW-1:0] mem_wdata;
   logic [LINEW-1:0] mem_rdata;
   logic             mem_ready;
   logic [PTRW:0]    occupancy;

   int checks   = 0;
   int failures = 0;

   // Reference: buffered lines in age order, coherent L2 view, memory contents.
   logic [ADDRW-1:0] q_addr[$];
   logic [LINEW-1:0] q_data[$];
   logic [LINEW-1:0] golden  [bit [ADDRW-1:0]];
   logic [LINEW-1:0] backing [bit [ADDRW-1:0]];

   always #5 clk = ~clk;

   l2_mem_write_buffer #(.DEPTH(DEPTH), .PTRW(PTRW)) dut (
      .clk       (clk),
      .reset     (reset),
      .up_read   (up_read),
      .up_write  (up_write),
      .up_addr   (up_addr),
      .up_wdata  (up_wdata),
      .up_rdata  (up_rdata),
      .up_ready  (up_ready),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .occupancy (occupancy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      up_read   = 1'b0;
      up_write  = 1'b0;
      mem_ready = 1'b0;
   endtask

   task automatic apply_reset();
      idle_in();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic issue(input bit wr, input logic [ADDRW-1:0] a, input logic [LINEW-1:0] d);
      up_write = wr;
      up_read  = !wr;
      up_addr  = a;
      up_wdata = d;
      tick();
   endtask

   // L2 keeps its request up through the ready cycle, then drops it.
   task automatic release_req();
      tick();
      up_read  = 1'b0;
      up_write = 1'b0;
   endtask

   task automatic mem_pulse(input logic [LINEW-1:0] rd);
      mem_rdata = rd;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
   endtask

   task automatic test_reset();
      up_write = 1'b1; up_read = 1'b1; up_addr = 28'h123; up_wdata = '1;
      mem_ready = 1'b1; mem_rdata = '1;
      reset = 1'b1;
      tick();
      checks++;
      if (up_ready !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0)
         begin failures++; $display("FAIL reset_ctrl: got rdy=%b rd=%b wr=%b expected 0 0 0", up_ready, mem_read, mem_write); end
      checks++;
      if (mem_addr !== '0 || mem_wdata !== '0 || up_rdata !== '0)
         begin failures++; $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h expected 0", mem_addr, mem_wdata, up_rdata); end
      checks++;
      if (occupancy !== 3'd0) begin failures++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
      idle_in();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_write_drain();
      apply_reset();
      issue(1'b1, 28'h0000010, {16{8'hAA}});
      checks++;
      if (up_ready !== 1'b1 || occupancy !== 3'd1)
         begin failures++; $display("FAIL wr_accept: got rdy=%b occ=%0d expected 1 1", up_ready, occupancy); end
      release_req();
      checks++;
      if (up_ready !== 1'b0 || mem_write !== 1'b1 || mem_addr !== 28'h0000010 || mem_wdata !== {16{8'hAA}})
         begin failures++; $display("FAIL drain_start: got rdy=%b wr=%b addr=%h data=%h expected 0 1 0000010 aa..", up_ready, mem_write, mem_addr, mem_wdata); end
      tick();
      tick();
      checks++;
      if (mem_write !== 1'b1) begin failures++; $display("FAIL drain_hold: got %b expected 1", mem_write); end
      mem_pulse('0);
      checks++;
      if (mem_write !== 1'b0 || occupancy !== 3'd0)
         begin failures++; $display("FAIL drain_done: got wr=%b occ=%0d expected 0 0", mem_write, occupancy); end
   endtask

   task automatic test_coalesce();
      apply_reset();
      issue(1'b1, 28'h100, 128'h1);
      release_req();
      issue(1'b1, 28'h20, 128'hD1);
      release_req();
      issue(1'b1, 28'h20, 128'hD2);
      checks++;
      if (up_ready !== 1'b1 || occupancy !== 3'd2)
         begin failures++; $display("FAIL coalesce_occ: got rdy=%b occ=%0d expected 1 2", up_ready, occupancy); end
      release_req();
      mem_pulse('0);
      tick();
      checks++;
      if (mem_write !== 1'b1 || mem_addr !== 28'h20 || mem_wdata !== 128'hD2 || occupancy !== 3'd1)
         begin failures++; $display("FAIL coalesce_data: got wr=%b addr=%h data=%h occ=%0d expected 1 20 d2 1", mem_write, mem_addr, mem_wdata, occupancy); end
      mem_pulse('0);
   endtask

   task automatic test_full_stall();
      int early;
      apply_reset();
      for (int i = 0; i < DEPTH; i++) begin
         issue(1'b1, 28'h30 + 28'(i), 128'(i + 1));
         checks++;
         if (up_ready !== 1'b1) begin failures++; $display("FAIL fill_%0d: got rdy=%b expected 1", i, up_ready); end
         release_req();
      end
      checks++;
      if (occupancy !== 3'd4) begin failures++; $display("FAIL full_occ: got %0d expected 4", occupancy); end
      issue(1'b1, 28'h40, 128'h55);
      early = int'(up_ready);
      for (int i = 0; i < 5; i++) begin
         tick();
         early += int'(up_ready);
      end
      checks++;
      if (early != 0) begin failures++; $display("FAIL full_stall: got %0d ready pulses expected 0", early); end
      mem_pulse('0);
      checks++;
      if (up_ready !== 1'b0 || occupancy !== 3'd3)
         begin failures++; $display("FAIL full_pop: got rdy=%b occ=%0d expected 0 3", up_ready, occupancy); end
      tick();
      checks++;
      if (up_ready !== 1'b1 || occupancy !== 3'd4)
         begin failures++; $display("FAIL full_accept: got rdy=%b occ=%0d expected 1 4", up_ready, occupancy); end
      release_req();
   endtask

   task automatic test_read_hit();
      int rds;
      apply_reset();
      issue(1'b1, 28'h5, 128'h1234);
      release_req();
      issue(1'b0, 28'h5, '0);
      checks++;
      if (up_ready !== 1'b1 || up_rdata !== 128'h1234)
         begin failures++; $display("FAIL read_hit: got rdy=%b data=%h expected 1 1234", up_ready, up_rdata); end
      rds = int'(mem_read);
      release_req();
      for (int i = 0; i < 3; i++) begin
         rds += int'(mem_read);
         tick();
      end
      checks++;
      if (rds != 0) begin failures++; $display("FAIL read_hit_mem: got %0d mem_read cycles expected 0", rds); end
   endtask

   task automatic test_read_miss_drain();
      int early;
      apply_reset();
      issue(1'b1, 28'h50, 128'h77);
      release_req();
      issue(1'b0, 28'h9, '0);
      early = int'(mem_read) + int'(up_ready);
      tick();
      early += int'(mem_read) + int'(up_ready);
      tick();
      early += int'(mem_read) + int'(up_ready);
      checks++;
      if (early != 0) begin failures++; $display("FAIL miss_wait: got %0d early events expected 0", early); end
      mem_pulse(128'hDEAD);
      checks++;
      if (mem_write !== 1'b0 || mem_read !== 1'b0)
         begin failures++; $display("FAIL miss_overlap: got wr=%b rd=%b expected 0 0", mem_write, mem_read); end
      tick();
      checks++;
      if (mem_read !== 1'b1 || mem_addr !== 28'h9)
         begin failures++; $display("FAIL miss_issue: got rd=%b addr=%h expected 1 0000009", mem_read, mem_addr); end
      mem_pulse(128'hBEEF);
      checks++;
      if (up_ready !== 1'b1 || up_rdata !== 128'hBEEF || mem_read !== 1'b0)
         begin failures++; $display("FAIL miss_return: got rdy=%b data=%h rd=%b expected 1 beef 0", up_ready, up_rdata, mem_read); end
      release_req();
      checks++;
      if (up_ready !== 1'b0 || mem_read !== 1'b0)
         begin failures++; $display("FAIL miss_reaccept: got rdy=%b rd=%b expected 0 0", up_ready, mem_read); end
   endtask

   task automatic test_reset_mid_read();
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         issue(1'b1, 28'h60 + 28'(i), 128'(i + 9));
         release_req();
      end
      issue(1'b0, 28'h70, '0);
      mem_pulse('0);
      tick();
      checks++;
      if (mem_read !== 1'b1 || occupancy !== 3'd2)
         begin failures++; $display("FAIL rdmem_setup: got rd=%b occ=%0d expected 1 2", mem_read, occupancy); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (up_ready !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== '0 || occupancy !== 3'd0)
         begin failures++; $display("FAIL midreset: got rdy=%b rd=%b wr=%b addr=%h occ=%0d expected all 0", up_ready, mem_read, mem_write, mem_addr, occupancy); end
      tick();
      checks++;
      if (mem_read !== 1'b1 || mem_addr !== 28'h70 || mem_write !== 1'b0)
         begin failures++; $display("FAIL midreset_fresh: got rd=%b addr=%h wr=%b expected 1 0000070 0", mem_read, mem_addr, mem_write); end
      mem_pulse('0);
      release_req();
   endtask

   task automatic test_random();
      bit               active, is_wr, hold, excl, rhit, exp_rdy;
      logic [ADDRW-1:0] a;
      logic [LINEW-1:0] d, exp_d;
      logic             pre_mw, pre_mr, pre_rdy;
      int               pre_size, midx, waitc, slow;
      active = 0; is_wr = 0; hold = 0; waitc = 0; a = '0; d = '0;
      apply_reset();
      q_addr.delete(); q_data.delete(); golden.delete(); backing.delete();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         slow = (cyc < 2000) ? 5 : 1;
         if (hold) begin
            hold = 0;
         end else if (!active) begin
            up_read  = 1'b0;
            up_write = 1'b0;
            if ($urandom_range(0, 2) != 0) begin
               active   = 1;
               waitc    = 0;
               is_wr    = 1'($urandom_range(0, 1));
               a        = 28'h100 + 28'($urandom_range(0, 9));
               d        = {$urandom, $urandom, $urandom, $urandom};
               up_addr  = a;
               up_wdata = d;
               up_write = is_wr;
               up_read  = is_wr ? ($urandom_range(0, 7) == 0) : 1'b1;
            end
         end
         mem_ready = (mem_read || mem_write) && ($urandom_range(0, slow) == 0);
         if (mem_read)
            mem_rdata = backing.exists(mem_addr) ? backing[mem_addr] : '0;
         else
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
         pre_mw = mem_write; pre_mr = mem_read; pre_rdy = mem_ready;
         pre_size = q_addr.size();
         tick();

         exp_rdy = 0;
         midx = -1;
         if (active && is_wr) begin
            excl = pre_mw || mem_write;
            for (int i = 0; i < q_addr.size(); i++)
               if (q_addr[i] == a && !(excl && i == 0)) midx = i;
            exp_rdy = (pre_size < DEPTH) || (midx >= 0);
         end else if (active && !pre_mr) begin
            rhit = 0;
            foreach (q_addr[i]) if (q_addr[i] == a) rhit = 1;
            exp_rdy = rhit;
         end
         if (pre_mr && pre_rdy) exp_rdy = 1;
         checks++;
         if (up_ready !== exp_rdy)
            begin failures++; $display("FAIL rnd_ready cyc=%0d: got %b expected %b", cyc, up_ready, exp_rdy); end
         if (up_ready && active && !is_wr) begin
            exp_d = golden.exists(a) ? golden[a] : '0;
            checks++;
            if (up_rdata !== exp_d)
               begin failures++; $display("FAIL rnd_rdata cyc=%0d addr=%h: got %h expected %h", cyc, a, up_rdata, exp_d); end
         end
         if (exp_rdy && active && is_wr) begin
            golden[a] = d;
            if (midx >= 0) q_data[midx] = d;
            else begin q_addr.push_back(a); q_data.push_back(d); end
         end
         if (pre_mw && pre_rdy && q_addr.size() > 0) begin
            backing[q_addr[0]] = q_data[0];
            void'(q_addr.pop_front());
            void'(q_data.pop_front());
         end
         if (up_ready) begin active = 0; hold = 1; end

         checks++;
         if (occupancy !== (PTRW+1)'(q_addr.size()))
            begin failures++; $display("FAIL rnd_occ cyc=%0d: got %0d expected %0d", cyc, occupancy, q_addr.size()); end
         checks++;
         if (mem_read && mem_write)
            begin failures++; $display("FAIL rnd_excl cyc=%0d: got rd=1 wr=1 expected not both", cyc); end
         if (mem_write) begin
            checks++;
            if (q_addr.size() == 0 || mem_addr !== q_addr[0] || mem_wdata !== q_data[0])
               begin failures++; $display("FAIL rnd_drain cyc=%0d: got addr=%h data=%h expected oldest buffered line", cyc, mem_addr, mem_wdata); end
         end
         if (mem_read) begin
            checks++;
            if (!(active && !is_wr) || mem_addr !== a)
               begin failures++; $display("FAIL rnd_memrd cyc=%0d: got addr=%h expected pending read addr %h", cyc, mem_addr, a); end
         end
         if (active) begin
            waitc++;
            if (waitc > 300) begin
               failures++;
               $display("FAIL rnd_timeout cyc=%0d: got no up_ready within 300 cycles expected completion", cyc);
               break;
            end
         end
      end
      idle_in();
   endtask

   initial begin
      reset = 1'b1;
      up_addr = '0; up_wdata = '0; mem_rdata = '0;
      idle_in();
      test_reset();
      test_write_drain();
      test_coalesce();
      test_full_stall();
      test_read_hit();
      test_read_miss_drain();
      test_reset_mid_read();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
